// File: rtl/hilo_mult_unit_if.sv
// HI/LO control bundle between the controller/datapath and hilo_mult_unit.
// master: issues ops and operands; slave: returns HI/LO, read data, Busy/Done/Stall.
interface hilo_mult_unit_if;
  logic        Issue;
  logic [4:0]  ALUOp;
  logic        Hi_write;
  logic        Lo_write;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [31:0] HiLoOut;
  logic        Busy;
  logic        Done;
  logic        Stall;

  modport master (
    output Issue, ALUOp, Hi_write, Lo_write, A, B,
    input  Hi, Lo, HiLoOut, Busy, Done, Stall
  );

  modport slave (
    input  Issue, ALUOp, Hi_write, Lo_write, A, B,
    output Hi, Lo, HiLoOut, Busy, Done, Stall
  );
endinterface

// File: rtl/hilo_mult_unit.sv
// HI/LO owner: 32-step shift-add mult/multu/madd/msub, 1-cycle mthi/mtlo, mfhi/mflo read.
// Ports: Clk, Reset (async high), bus (slave: Issue/ALUOp/enables/A/B in; Hi/Lo/HiLoOut/Busy/Done/Stall out).
module hilo_mult_unit (
  input logic Clk,
  input logic Reset,
  hilo_mult_unit_if.slave bus
);
  localparam logic [4:0] OpMult  = 5'b00010;
  localparam logic [4:0] OpMultu = 5'b11000;
  localparam logic [4:0] OpMadd  = 5'b01111;
  localparam logic [4:0] OpMsub  = 5'b01110;
  localparam logic [4:0] OpMthi  = 5'b10010;
  localparam logic [4:0] OpMtlo  = 5'b10011;
  localparam logic [4:0] OpMfhi  = 5'b10100;
  localparam logic [4:0] OpMflo  = 5'b10101;

  typedef enum logic [1:0] {Idle, Mul, Fin} state_t;
  typedef enum logic [1:0] {KSet, KAdd, KSub} kind_t;

  state_t state, stateNext;
  kind_t kind, kindIn;

  logic [31:0] hiQ, loQ, mplier, absA, absB;
  logic [63:0] prod, mcand, signedProd, acc, result;
  logic [5:0]  count;
  logic negQ, doneQ, busy;
  logic isMul, isSigned, isHiLo;
  logic accept, mulGo, mthiGo, mtloGo;

  always_comb begin
    isMul = 1'b0;
    isSigned = 1'b0;
    kindIn = KSet;
    unique case (bus.ALUOp)
      OpMult: begin
        isMul = 1'b1;
        isSigned = 1'b1;
      end
      OpMultu: isMul = 1'b1;
      OpMadd: begin
        isMul = 1'b1;
        isSigned = 1'b1;
        kindIn = KAdd;
      end
      OpMsub: begin
        isMul = 1'b1;
        isSigned = 1'b1;
        kindIn = KSub;
      end
      default: ;
    endcase
  end

  assign isHiLo = isMul
    | (bus.ALUOp == OpMthi) | (bus.ALUOp == OpMtlo)
    | (bus.ALUOp == OpMfhi) | (bus.ALUOp == OpMflo);

  assign busy   = (state != Idle);
  assign accept = bus.Issue & ~busy;
  assign mulGo  = accept & isMul & bus.Hi_write & bus.Lo_write;
  assign mthiGo = accept & (bus.ALUOp == OpMthi) & bus.Hi_write;
  assign mtloGo = accept & (bus.ALUOp == OpMtlo) & bus.Lo_write;

  // -2^31 negates to 0x80000000, which is exactly 2^31 as unsigned.
  assign absA = (isSigned && bus.A[31]) ? -bus.A : bus.A;
  assign absB = (isSigned && bus.B[31]) ? -bus.B : bus.B;

  assign signedProd = negQ ? -prod : prod;
  assign acc = {hiQ, loQ};

  always_comb begin
    result = signedProd;
    unique case (kind)
      KAdd:    result = acc + signedProd;
      KSub:    result = acc - signedProd;
      default: result = signedProd;
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle:    if (mulGo) stateNext = Mul;
      Mul:     if (count == 6'd31) stateNext = Fin;
      Fin:     stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= Idle;
    else       state <= stateNext;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hiQ    <= '0;
      loQ    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      negQ   <= 1'b0;
      kind   <= KSet;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (state)
        Idle: begin
          if (mulGo) begin
            mcand  <= {32'd0, absA};
            mplier <= absB;
            prod   <= '0;
            count  <= '0;
            negQ   <= isSigned & (bus.A[31] ^ bus.B[31]);
            kind   <= kindIn;
          end
          if (mthiGo) hiQ <= bus.A;
          if (mtloGo) loQ <= bus.A;
        end
        Mul: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 6'd1;
        end
        Fin: begin
          {hiQ, loQ} <= result;
          doneQ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi    = hiQ;
  assign bus.Lo    = loQ;
  assign bus.Busy  = busy;
  assign bus.Done  = doneQ;
  assign bus.Stall = bus.Issue & busy & isHiLo;

  assign bus.HiLoOut = (bus.ALUOp == OpMfhi) ? hiQ :
                       (bus.ALUOp == OpMflo) ? loQ : 32'd0;
endmodule
